bit_serial_adder: RTL

//  Multi-cycle WIDTH-bit add/subtract unit. Processes one bit per clock through a single full-adder cell and a carry flip-flop.
//  Low-area alternative to the ripple-carry adder. Sits behind the ALU issue logic.

---
 rtl/bit_serial_adder_pkg.sv | 20 ++
 rtl/bit_serial_adder_full_adder.sv | 13 +
 rtl/bit_serial_adder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared arithmetic types for the bit-serial adder and the ALU: FSM state
// encoding, NZCV flag bundle and the default operand width.
package bit_serial_adder_pkg;

  localparam int BSA_DEFAULT_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bsa_state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage : bit_serial_adder_pkg

// File: rtl/bit_serial_adder_full_adder.sv
// Single-bit full-adder cell shared by the serial arithmetic units.
module fullAdder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule : fullAdder

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit add/subtract unit with valid/ready handshakes; one bit per clock.
// Optional NZCV flag generation is built when BIT_SERIAL_ADDER_FLAGS_EN is defined.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = BSA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);

  bsa_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, result_q, result_d;
  logic [CW-1:0]    count_q;
  logic             carry_q;
  logic             fa_s, fa_cout;
  logic             accept, out_fire, last_bit;

  fullAdder u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_cout)
  );

  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_bit = (state_q == RUN) && (count_q == CNT_LAST);
  assign result_d = {fa_s, result_q[WIDTH-1:1]};

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_d = RUN;
      end
      RUN: begin
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset)                result_q <= '0;
    else if (state_q == RUN)  result_q <= result_d;
  end

  // NOTE: the operand shifters, carry and counter carry no reset: they are
  // always reloaded on accept before they are used, and the FSM alone
  // decides whether their contents matter.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q     <= a;
      b_q     <= b ^ {WIDTH{sub}};
      carry_q <= sub;
      count_q <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      carry_q <= fa_cout;
      count_q <= count_q + CW'(1);
    end
  end

`ifdef BIT_SERIAL_ADDER_FLAGS_EN
  nzcv_t flags_q;
  logic  c_msb_q;

  // c_msb_q holds the carry into the MSB, taken as the carry-out of bit WIDTH-2.
  always_ff @(posedge clk) begin
    if ((state_q == RUN) && (count_q == CNT_MSB_IN)) c_msb_q <= fa_cout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else if (last_bit) begin
      flags_q.n <= fa_s;
      flags_q.z <= (result_d == '0);
      flags_q.c <= fa_cout;
      flags_q.v <= c_msb_q ^ fa_cout;
    end
  end

  assign flag_n = flags_q.n;
  assign flag_z = flags_q.z;
  assign flag_c = flags_q.c;
  assign flag_v = flags_q.v;
`else
  assign flag_n = 1'b0;
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
  assign flag_v = 1'b0;
`endif

  assign result = result_q;

endmodule : bit_serial_adder
